// File: rtl/sd_req_sequencer.sv
// rtl/sd_req_sequencer.sv - SD_CLK-side sequencer draining AXI->SDRAM FIFOs into single SDRAM core commands
module sd_req_sequencer #(
  parameter int              SIZE         = 32,
  parameter int              RSP_TIMEOUT  = 1023,
  parameter logic [SIZE-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic            SD_CLK,
  input  logic            ARESETn,
  input  logic            RW_FIFO_EMPTY,
  input  logic            SD_RW_OUT,
  output logic            SD_RW_EN,
  input  logic            WADDR_FIFO_EMPTY,
  input  logic [SIZE-1:0] SD_WR_ADDR_OUT,
  output logic            SD_WR_ADDR_EN,
  input  logic            WDATA_FIFO_EMPTY,
  input  logic [SIZE-1:0] SD_WR_DATA_OUT,
  output logic            SD_WR_DATA_EN,
  input  logic            RADDR_FIFO_EMPTY,
  input  logic [SIZE-1:0] SD_RD_ADDR_OUT,
  output logic            SD_RD_ADDR_EN,
  input  logic            RDATA_FIFO_FULL,
  output logic [SIZE-1:0] SD_RD_DATA_IN,
  output logic            SD_RD_DATA_EN,
  output logic            CMD_VALID,
  input  logic            CMD_READY,
  output logic            CMD_WRITE,
  output logic [SIZE-1:0] CMD_ADDR,
  output logic [SIZE-1:0] CMD_WDATA,
  input  logic            RSP_VALID,
  input  logic [SIZE-1:0] RSP_DATA,
  output logic            BUSY,
  output logic            TIMEOUT_ERR
);

  localparam int             CW       = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(RSP_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TAG, S_WCHK, S_WCAP, S_RCHK, S_RCAP, S_ISSUE, S_RWAIT, S_PUSH
  } state_t;

  state_t          state_q, state_d;
  logic            run_q;
  logic            write_q, write_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [SIZE-1:0] wdata_q, wdata_d;
  logic [SIZE-1:0] rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic rw_en, wr_en, rd_addr_en, rd_data_en, cmd_valid, tmo;

  // run_q keeps IDLE from popping in the first cycle after reset release
  always_ff @(posedge SD_CLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    rw_en      = 1'b0;
    wr_en      = 1'b0;
    rd_addr_en = 1'b0;
    rd_data_en = 1'b0;
    cmd_valid  = 1'b0;
    tmo        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_q && !RW_FIFO_EMPTY) begin
          rw_en   = 1'b1;
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        write_d = SD_RW_OUT;
        state_d = SD_RW_OUT ? S_WCHK : S_RCHK;
      end
      S_WCHK: begin
        if (!WADDR_FIFO_EMPTY && !WDATA_FIFO_EMPTY) begin
          wr_en   = 1'b1;
          state_d = S_WCAP;
        end
      end
      S_WCAP: begin
        addr_d  = SD_WR_ADDR_OUT;
        wdata_d = SD_WR_DATA_OUT;
        state_d = S_ISSUE;
      end
      S_RCHK: begin
        if (!RADDR_FIFO_EMPTY) begin
          rd_addr_en = 1'b1;
          state_d    = S_RCAP;
        end
      end
      S_RCAP: begin
        addr_d  = SD_RD_ADDR_OUT;
        wdata_d = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (CMD_READY) begin
          if (write_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_RWAIT;
          end
        end
      end
      S_RWAIT: begin
        cnt_d = cnt_q + 1'b1;
        // a response arriving on the limit cycle takes priority over the timeout
        if (RSP_VALID) begin
          rdata_d = RSP_DATA;
          state_d = S_PUSH;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = TIMEOUT_DATA;
          tmo     = 1'b1;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (!RDATA_FIFO_FULL) begin
          rd_data_en = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign SD_RW_EN      = rw_en;
  assign SD_WR_ADDR_EN = wr_en;
  assign SD_WR_DATA_EN = wr_en;
  assign SD_RD_ADDR_EN = rd_addr_en;
  assign SD_RD_DATA_EN = rd_data_en;
  assign SD_RD_DATA_IN = rdata_q;
  assign CMD_VALID     = cmd_valid;
  assign CMD_WRITE     = write_q;
  assign CMD_ADDR      = addr_q;
  assign CMD_WDATA     = wdata_q;
  assign BUSY          = (state_q != S_IDLE);
  assign TIMEOUT_ERR   = tmo;

endmodule

// File: doc/sd_req_sequencer.md
Name: sd_req_sequencer

Overview:
- SD_CLK-domain consumer of the AXI-to-SDRAM clock-crossing FIFOs.
- Pops the read/write tag from the RW FIFO. For writes it pops the WADDR and WDATA FIFOs; for reads it pops the RADDR FIFO.
- Issues one command at a time to the SDRAM core through a valid/ready handshake.
- For reads, captures the core's response and pushes it into the RDATA FIFO, with backpressure and a response timeout.

Parameters:
- SIZE, 32, address/data width.
- RSP_TIMEOUT, 1023, SD_CLK cycles to wait for a read response after command acceptance.
- TIMEOUT_DATA, 32'hDEAD_BEEF, word pushed to RDATA on timeout.

Ports:
- SD_CLK  in  1  SDRAM-domain clock; all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- RW_FIFO_EMPTY  in  1  RW tag FIFO empty.
- SD_RW_OUT  in  1  RW tag from FIFO; 1=write, 0=read.
- SD_RW_EN  out  1  RW FIFO pop strobe.
- WADDR_FIFO_EMPTY  in  1  write-address FIFO empty.
- SD_WR_ADDR_OUT  in  SIZE  write address from FIFO.
- SD_WR_ADDR_EN  out  1  WADDR pop strobe.
- WDATA_FIFO_EMPTY  in  1  write-data FIFO empty.
- SD_WR_DATA_OUT  in  SIZE  write data from FIFO.
- SD_WR_DATA_EN  out  1  WDATA pop strobe.
- RADDR_FIFO_EMPTY  in  1  read-address FIFO empty.
- SD_RD_ADDR_OUT  in  SIZE  read address from FIFO.
- SD_RD_ADDR_EN  out  1  RADDR pop strobe.
- RDATA_FIFO_FULL  in  1  read-data FIFO full.
- SD_RD_DATA_IN  out  SIZE  read data to RDATA FIFO.
- SD_RD_DATA_EN  out  1  RDATA push strobe.
- CMD_VALID  out  1  command valid to SDRAM core.
- CMD_READY  in  1  core accepts command.
- CMD_WRITE  out  1  1=write, 0=read.
- CMD_ADDR  out  SIZE  command address.
- CMD_WDATA  out  SIZE  write data.
- RSP_VALID  in  1  one-cycle read response strobe from core.
- RSP_DATA  in  SIZE  read response data.
- BUSY  out  1  high in any state other than IDLE.
- TIMEOUT_ERR  out  1  one-cycle pulse on read timeout.

Behaviour:

FIFO interface:
- FIFO read is pop-then-capture: data_out is valid the cycle after the rd_en pulse.
- Every pop/push strobe is exactly one cycle wide.

Reset:
- All outputs are 0 and the state is IDLE.
- Address/data registers are 0 and the timeout counter is 0.
- Reset mid-operation abandons the transaction immediately; no strobe is emitted after deassertion until IDLE re-evaluates.

State machine:
- IDLE:
  - If !RW_FIFO_EMPTY: pulse SD_RW_EN and go to TAG.
- TAG:
  - Capture SD_RW_OUT into the write flag.
  - Go to WCHK if write, else RCHK.
- WCHK:
  - Wait until !WADDR_FIFO_EMPTY && !WDATA_FIFO_EMPTY.
  - Then pulse SD_WR_ADDR_EN and SD_WR_DATA_EN in the same cycle and go to WCAP.
  - Never pop only one of the two.
- WCAP:
  - Latch the address/data.
  - Go to ISSUE.
- RCHK:
  - Wait until !RADDR_FIFO_EMPTY.
  - Then pulse SD_RD_ADDR_EN and go to RCAP.
- RCAP:
  - Latch the address.
  - Go to ISSUE.
- ISSUE:
  - CMD_VALID=1 with CMD_WRITE/CMD_ADDR/CMD_WDATA held stable until CMD_READY is sampled high.
  - On acceptance, drop CMD_VALID next cycle.
  - Write: go to IDLE. Read: clear the counter and go to RWAIT.
  - CMD_WDATA is 0 for reads.
- RWAIT:
  - Counter increments each cycle.
  - On RSP_VALID: latch RSP_DATA and go to PUSH.
  - If the counter reaches RSP_TIMEOUT with no response: latch TIMEOUT_DATA, pulse TIMEOUT_ERR, and go to PUSH.
  - RSP_VALID in the same cycle the limit is reached wins; no error.
- PUSH:
  - Wait while RDATA_FIFO_FULL.
  - When not full: pulse SD_RD_DATA_EN with SD_RD_DATA_IN = latched word, then go to IDLE.
  - SD_RD_DATA_IN holds its value otherwise.

Ordering and response handling:
- One outstanding command maximum; strict RW-tag order is preserved.
- RSP_VALID outside RWAIT is ignored.

Timing:
- Minimum write turnaround, IDLE-to-IDLE with CMD_READY tied high: 5 cycles.
- Minimum read turnaround with RSP_VALID on the first RWAIT cycle and RDATA not full: 7 cycles.
- Back-to-back transactions: IDLE re-pops the next tag the cycle after returning.

Test Plan:
1. Write 0x0000_0040/0xA5A5_5A5A, CMD_READY high -> single CMD_VALID cycle, CMD_WRITE=1, fields match; no RDATA push.
2. Read addr 0x80, core answers RSP_DATA=0x1234_5678 after 3 cycles -> CMD_WRITE=0, one SD_RD_DATA_EN with 0x1234_5678.
3. Tags W,R,W queued, CMD_READY low 4 cycles on the first -> CMD fields stable while stalled; commands issued in order W,R,W.
4. Write tag present, WDATA empty 10 cycles -> no WADDR pop until both non-empty; then simultaneous pops.
5. Read, RDATA_FIFO_FULL high 6 cycles after response -> push delayed until not full; data unchanged.
6. Read, no RSP_VALID, RSP_TIMEOUT=15 -> TIMEOUT_ERR pulse after 15 RWAIT cycles; 0xDEAD_BEEF pushed. Reset asserted mid-RWAIT -> all outputs 0, state IDLE.
